noc_rr_switch_arbiter: RTL and testbench
========================================

# noc_rr_switch_arbiter

Parametrised per-output switch allocator for the NoC router. It replaces fixed 5-port time-division turn rotation with request-aware round-robin arbitration that holds each output for a whole wormhole packet. A legacy TDM mode is retained for bring-up. It sits between the input-port route-computation stage and the crossbar select logic.

## Interface
Parameters:
- NUM_PORTS, 5, number of router ports (inputs = outputs); legal range ≥ 2.
- MODE, 0, 0 = request-aware round-robin with packet lock; 1 = legacy TDM rotation.
- ALLOW_UTURN, 0, 0 = input i may never be granted output i; 1 = allowed.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_i  in  NUM_PORTS*NUM_PORTS  bit [o*NUM_PORTS+i] = input i requests output o. Upstream guarantees at most one output per input per cycle.
- tail_i  in  NUM_PORTS  bit i = head flit of input i is a packet tail.
- xfer_i  in  NUM_PORTS  bit o = a flit crossed output o this cycle (granted input valid & downstream ready).
- grant_o  out  NUM_PORTS*NUM_PORTS  bit [o*NUM_PORTS+i] = input i owns output o. Registered; one-hot or zero per output.
- busy_o  out  NUM_PORTS  bit o = output o is locked to an owner. Registered.

## Operation
- NUM_PORTS independent per-output arbiters. Each has state IDLE/LOCKED, an owner index, and a round-robin pointer ptr[o] of width clog2(NUM_PORTS). Reset value of ptr[o] is (o+1) mod NUM_PORTS.
- Masked request for output o: req_i slice for o; bit o is cleared when ALLOW_UTURN=0.
- MODE 0, IDLE:
  - If the masked request is nonzero, the winner is the first requester at index ≥ ptr[o], searched cyclically.
  - Next cycle: state LOCKED, owner = winner, grant bit set, busy_o[o]=1, ptr[o] = (winner+1) mod NUM_PORTS.
  - If no requests, grant stays zero.
- MODE 0, LOCKED: grant held constant. Release occurs when either:
  - xfer_i[o] && tail_i[owner] (packet end), or
  - the owner's request bit drops (abort).
  - On release, the next cycle is IDLE with grant zero and busy_o[o]=0. No arbitration occurs in the release cycle (one-cycle bubble per packet).
  - Release has priority over everything; new requests are ignored while LOCKED.
- Multiple outputs may grant different inputs in the same cycle. Because each input requests only one output, no input ever receives two grants.
- MODE 1 (TDM):
  - req_i, tail_i, and xfer_i are ignored; busy_o is constant 0.
  - Each output's grant is one-hot and rotates every cycle to the next lower input index, modulo NUM_PORTS.
  - Index o is skipped when ALLOW_UTURN=0, giving period NUM_PORTS-1; otherwise the period is NUM_PORTS.
  - Reset grant for output o is input (o+1) mod NUM_PORTS.

## Timing
- Reset: MODE 0 grant_o=0, busy_o=0, all arbiters IDLE, ptr per above. MODE 1 grant per TDM reset value.
- Reset mid-packet: grant_o and busy_o clear on the next edge; locks and pointers return to reset values.
- Grant latency: request sampled at edge t produces grant at t+1.
- Release latency: tail transfer or request drop at t clears grant at t+1. Earliest re-grant is t+2.
- Single-flit packet (tail on first xfer): grant lasts exactly one cycle if xfer occurs immediately.
- xfer_i without tail leaves state unchanged. xfer_i while IDLE is ignored.
- Pointer wrap: winner NUM_PORTS-1 sets ptr to 0.

## Test plan
- Reset, NUM_PORTS=5, MODE 0 -> grant_o=0 and busy_o=0 on the first cycle after rst; ptr values 1,2,3,4,0 (checked via first arbitration outcomes).
- Input 2 requests output 0 at t. 4-flit packet with xfer each cycle from t+1, tail on the 4th -> grant bit [2] set t+1..t+4, cleared at t+5; busy_o[0] tracks the grant.
- Inputs 1, 3, 4 continuously request output 0 with 2-flit packets -> grant order 1, 3, 4, 1, with one idle cycle between packets.
- ALLOW_UTURN=0, input 2 requests only output 2 for 20 cycles -> no grant. With ALLOW_UTURN=1 -> grant at t+1.
- Owner input 3 locked on output 1 drops its request mid-packet at t -> grant cleared at t+1. Pending input 4 granted at t+2. Separately, rst asserted mid-packet -> all grants 0 next cycle.
- MODE 1, NUM_PORTS=5, ALLOW_UTURN=0 -> output 0 grant sequence from reset: inputs 1, 4, 3, 2, 1; output 4 sequence: 0, 3, 2, 1, 0; unaffected by req_i activity.

Source files
------------

// File: rtl/noc_rr_switch_arbiter.sv
// Per-output switch allocator: request-aware round-robin with wormhole packet lock,
// or legacy TDM rotation for bring-up. One arbiter instance per router output.

module noc_rr_out_arb #(
  parameter int NP          = 5,
  parameter int O           = 0,
  parameter int MODE        = 0,
  parameter int ALLOW_UTURN = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NP-1:0] req,
  input  logic [NP-1:0] tail,
  input  logic          xfer,
  output logic [NP-1:0] grant,
  output logic          busy
);
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [PW-1:0] LAST    = PW'(NP - 1);
  localparam logic [PW-1:0] OIDX    = PW'(O);
  localparam logic [PW-1:0] PTR_RST = (O == NP - 1) ? '0 : PW'(O + 1);

  typedef enum logic {IDLE, LOCKED} st_t;

  st_t           state, nstate;
  logic [PW-1:0] owner, nowner, ptr, nptr, tdm, ntdm, win;
  logic [NP-1:0] mreq;
  logic          found, rel;
  int            j;

  function automatic logic [PW-1:0] dec(input logic [PW-1:0] x);
    return (x == '0) ? LAST : x - PW'(1);
  endfunction

  always_comb begin
    mreq = req;
    if (ALLOW_UTURN == 0) mreq[O] = 1'b0;
  end

  // cyclic first-hit search starting at the round-robin pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < NP; k++) begin
      j = int'(ptr) + k;
      if (j >= NP) j = j - NP;
      if (!found && mreq[j]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  // owner's request is never masked (owner != O when U-turns are barred)
  assign rel = (state == LOCKED) && ((xfer && tail[owner]) || !req[owner]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= PTR_RST;
      tdm   <= PTR_RST;
    end else begin
      state <= nstate;
      owner <= nowner;
      ptr   <= nptr;
      tdm   <= ntdm;
    end
  end

  always_comb begin
    nstate = state;
    nowner = owner;
    nptr   = ptr;
    case (state)
      IDLE: if (found) begin
        nstate = LOCKED;
        nowner = win;
        nptr   = (win == LAST) ? '0 : win + PW'(1);
      end
      LOCKED: if (rel) nstate = IDLE;
      default: nstate = IDLE;
    endcase
    ntdm = dec(tdm);
    if (ALLOW_UTURN == 0 && ntdm == OIDX) ntdm = dec(ntdm);
  end

  always_comb begin
    grant = '0;
    busy  = 1'b0;
    if (MODE == 1) begin
      grant[tdm] = 1'b1;
    end else if (state == LOCKED) begin
      grant[owner] = 1'b1;
      busy         = 1'b1;
    end
  end
endmodule

module noc_rr_switch_arbiter #(
  parameter int NUM_PORTS   = 5,
  parameter int MODE        = 0,
  parameter int ALLOW_UTURN = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0]           tail_i,
  input  logic [NUM_PORTS-1:0]           xfer_i,
  output logic [NUM_PORTS*NUM_PORTS-1:0] grant_o,
  output logic [NUM_PORTS-1:0]           busy_o
);
  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    noc_rr_out_arb #(
      .NP(NUM_PORTS), .O(o), .MODE(MODE), .ALLOW_UTURN(ALLOW_UTURN)
    ) u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (req_i[o*NUM_PORTS +: NUM_PORTS]),
      .tail (tail_i),
      .xfer (xfer_i[o]),
      .grant(grant_o[o*NUM_PORTS +: NUM_PORTS]),
      .busy (busy_o[o])
    );
  end
endmodule

// File: tb/tb_noc_rr_switch_arbiter.sv
// Bench for noc_rr_switch_arbiter: directed vector table, hand sequences for
// multi-cycle corners, and randomized traffic against an integer-level model.

module tb_noc_rr_switch_arbiter;
  localparam int NP = 5;
  localparam int W  = NP * NP;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  req;
  logic [NP-1:0] tail, xfer;
  logic [W-1:0]  g0, g1, g2;
  logic [NP-1:0] b0, b1, b2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // RR, no U-turn
  noc_rr_switch_arbiter #(.NUM_PORTS(NP), .MODE(0), .ALLOW_UTURN(0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req), .tail_i(tail), .xfer_i(xfer), .grant_o(g0), .busy_o(b0));
  // RR, U-turn allowed
  noc_rr_switch_arbiter #(.NUM_PORTS(NP), .MODE(0), .ALLOW_UTURN(1)) dut1 (
    .clk(clk), .rst(rst), .req_i(req), .tail_i(tail), .xfer_i(xfer), .grant_o(g1), .busy_o(b1));
  // TDM, no U-turn
  noc_rr_switch_arbiter #(.NUM_PORTS(NP), .MODE(1), .ALLOW_UTURN(0)) dut2 (
    .clk(clk), .rst(rst), .req_i(req), .tail_i(tail), .xfer_i(xfer), .grant_o(g2), .busy_o(b2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_lock[2][NP];
  int m_own [2][NP];
  int m_ptr [2][NP];
  int m_tdm [NP];

  function automatic logic [W-1:0] m_grant(input int u);
    logic [W-1:0] g = '0;
    for (int o = 0; o < NP; o++) if (m_lock[u][o] != 0) g[o*NP + m_own[u][o]] = 1'b1;
    return g;
  endfunction

  function automatic logic [NP-1:0] m_busy(input int u);
    logic [NP-1:0] b = '0;
    for (int o = 0; o < NP; o++) b[o] = (m_lock[u][o] != 0);
    return b;
  endfunction

  function automatic logic [W-1:0] m_tdm_grant();
    logic [W-1:0] g = '0;
    for (int o = 0; o < NP; o++) g[o*NP + m_tdm[o]] = 1'b1;
    return g;
  endfunction

  task automatic model_step();
    for (int o = 0; o < NP; o++) begin
      if (rst) begin
        m_tdm[o] = (o + 1) % NP;
      end else begin
        m_tdm[o] = (m_tdm[o] + NP - 1) % NP;
        if (m_tdm[o] == o) m_tdm[o] = (m_tdm[o] + NP - 1) % NP;
      end
      for (int u = 0; u < 2; u++) begin
        if (rst) begin
          m_lock[u][o] = 0;
          m_own[u][o]  = 0;
          m_ptr[u][o]  = (o + 1) % NP;
        end else if (m_lock[u][o] != 0) begin
          if ((xfer[o] && tail[m_own[u][o]]) || !req[o*NP + m_own[u][o]]) m_lock[u][o] = 0;
        end else begin
          for (int k = 0; k < NP; k++) begin
            int i;
            i = (m_ptr[u][o] + k) % NP;
            if (m_lock[u][o] == 0 && req[o*NP + i] && (u == 1 || i != o)) begin
              m_lock[u][o] = 1;
              m_own[u][o]  = i;
              m_ptr[u][o]  = (i + 1) % NP;
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; tail = '0; xfer = '0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0]  req;
    logic [NP-1:0] tail;
    logic [NP-1:0] xfer;
    logic [W-1:0]  eg;
    logic [NP-1:0] eb;
  } vec_t;

  vec_t tbl[8];

  int exp_own[11];
  int exp_t0[5];
  int exp_t4[5];
  int cnt[NP];
  int dest[NP];
  int own;

  initial begin
    // 4-flit packet from input 2 to output 0, then idle xfer, then re-grant via wrapped pointer
    tbl[0] = '{req: 25'h4, tail: 5'h00, xfer: 5'h00, eg: 25'h4, eb: 5'h01};
    tbl[1] = '{req: 25'h4, tail: 5'h00, xfer: 5'h01, eg: 25'h4, eb: 5'h01};
    tbl[2] = '{req: 25'h4, tail: 5'h00, xfer: 5'h01, eg: 25'h4, eb: 5'h01};
    tbl[3] = '{req: 25'h4, tail: 5'h00, xfer: 5'h01, eg: 25'h4, eb: 5'h01};
    tbl[4] = '{req: 25'h4, tail: 5'h04, xfer: 5'h01, eg: 25'h0, eb: 5'h00};
    tbl[5] = '{req: 25'h0, tail: 5'h00, xfer: 5'h00, eg: 25'h0, eb: 5'h00};
    tbl[6] = '{req: 25'h0, tail: 5'h1f, xfer: 5'h1f, eg: 25'h0, eb: 5'h00};
    tbl[7] = '{req: 25'h4, tail: 5'h00, xfer: 5'h00, eg: 25'h4, eb: 5'h01};
    exp_own = '{1, 1, -1, 3, 3, -1, 4, 4, -1, 1, 1};
    exp_t0  = '{1, 4, 3, 2, 1};
    exp_t4  = '{0, 3, 2, 1, 0};

    do_reset();
    check("reset_grant", 64'(g0), 64'(0));
    check("reset_busy", 64'(b0), 64'(0));

    for (int v = 0; v < 8; v++) begin
      req = tbl[v].req; tail = tbl[v].tail; xfer = tbl[v].xfer;
      tick();
      check($sformatf("tbl%0d_grant", v), 64'(g0), 64'(tbl[v].eg));
      check($sformatf("tbl%0d_busy", v), 64'(b0), 64'(tbl[v].eb));
    end

    // inputs 1,3,4 contend for output 0 with 2-flit packets
    do_reset();
    for (int i = 0; i < NP; i++) cnt[i] = 0;
    req = 25'h1A;
    for (int c = 0; c < 11; c++) begin
      tick();
      own = -1;
      for (int i = 0; i < NP; i++) if (g0[i]) own = i;
      check($sformatf("rr_order%0d", c), 64'(own), 64'(exp_own[c]));
      xfer = '0; tail = '0;
      for (int i = 0; i < NP; i++) tail[i] = (cnt[i] == 1);
      if (own >= 0) begin
        xfer[0] = 1'b1;
        if (tail[own]) cnt[own] = 0; else cnt[own]++;
      end
    end

    // U-turn request: barred on dut0, immediate on dut1
    do_reset();
    req = 25'h1 << 12;
    tick();
    check("uturn_allowed", 64'(g1), 64'(25'h1 << 12));
    for (int c = 0; c < 19; c++) tick();
    check("uturn_barred", 64'(g0), 64'(0));

    // owner 3 on output 1 aborts; pending input 4 takes over after a bubble
    do_reset();
    req = (25'h1 << 8) | (25'h1 << 9);
    tick();
    check("abort_lock", 64'(g0), 64'(25'h1 << 8));
    tick();
    check("abort_hold", 64'(g0), 64'(25'h1 << 8));
    req = 25'h1 << 9;
    tick();
    check("abort_clear", 64'(g0), 64'(0));
    check("abort_busy", 64'(b0), 64'(0));
    tick();
    check("abort_next", 64'(g0), 64'(25'h1 << 9));
    rst = 1'b1;
    tick();
    check("midpkt_rst_grant", 64'(g0), 64'(0));
    check("midpkt_rst_busy", 64'(b0), 64'(0));
    rst = 1'b0;

    // TDM rotation ignores request activity
    do_reset();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("tdm_o0_%0d", c), 64'(g2[4:0]), 64'(5'h1 << exp_t0[c]));
      check($sformatf("tdm_o4_%0d", c), 64'(g2[24:20]), 64'(5'h1 << exp_t4[c]));
      check("tdm_busy", 64'(b2), 64'(0));
      req = W'($urandom); tail = NP'($urandom); xfer = NP'($urandom);
      tick();
    end

    // randomized traffic with occasional mid-packet reset
    do_reset();
    for (int i = 0; i < NP; i++) dest[i] = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NP; i++)
        if ($urandom_range(0, 3) == 0) begin
          dest[i] = $urandom_range(0, NP);
          if (dest[i] == NP) dest[i] = -1;
        end
      req = '0;
      for (int i = 0; i < NP; i++) if (dest[i] >= 0) req[dest[i]*NP + i] = 1'b1;
      tail = NP'($urandom);
      xfer = NP'($urandom);
      rst  = ($urandom_range(0, 60) == 0);
      tick();
      check("rnd_grant0", 64'(g0), 64'(m_grant(0)));
      check("rnd_busy0", 64'(b0), 64'(m_busy(0)));
      check("rnd_grant1", 64'(g1), 64'(m_grant(1)));
      check("rnd_busy1", 64'(b1), 64'(m_busy(1)));
      check("rnd_tdm", 64'(g2), 64'(m_tdm_grant()));
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
